// File: rtl/uart_sched_pkg.sv
// ============================================================================
// uart_sched_pkg : shared state encoding and sizing for uart_job_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_sched_pkg;

  localparam int NUM_REQ       = 2;
  localparam int DEF_RAM_SIZE  = 28;
  localparam int DEF_ADDR_BITS = 5;
  localparam int TIMEOUT_BITS  = 24;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin grant; the pointer remembers the last winner
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_idx,
  output logic [1:0] grant
);

  // last_idx = 1 out of reset so requester 0 wins the first tie
  logic last_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_idx <= 1'b1;
    end else if (upd_en) begin
      last_idx <= upd_idx;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_idx ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_job_scheduler.sv
// ============================================================================
// uart_job_scheduler : arbitrates two requesters, loads a job into the
// uart_handler RAM, starts it and reports completion.
// Optional build macro: UART_SCHED_TIMEOUT_EN (BUSY/WAIT timeout with err flag)
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_job_scheduler
  import uart_sched_pkg::*;
#(
  parameter int RAM_SIZE  = DEF_RAM_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  output logic [1:0]           gnt,
  input  logic [1:0]           in_valid,
  input  logic [7:0]           in_data0,
  input  logic [7:0]           in_data1,
  output logic [1:0]           in_ready,
  output logic [1:0]           done,
  output logic [ADDR_BITS-1:0] h_addr,
  output logic                 h_we,
  output logic [7:0]           h_data,
  output logic                 h_start,
  input  logic                 h_ready,
  output logic                 err
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_SIZE - 1);

  state_t               state;
  state_t               state_next;
  logic [ADDR_BITS-1:0] count;
  logic [1:0]           arb_grant;
  logic                 beat;
  logic                 last_beat;
  logic [7:0]           byte_in;
  logic                 tmo_hit;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .upd_en  (state == S_DONE),
    .upd_idx (gnt[1]),
    .grant   (arb_grant)
  );

  assign in_ready  = (state == S_LOAD) ? gnt : 2'b00;
  assign done      = (state == S_DONE) ? gnt : 2'b00;
  assign beat      = |(in_valid & in_ready);
  assign last_beat = beat && (count == LAST_ADDR);
  assign byte_in   = gnt[1] ? in_data1 : in_data0;

`ifdef UART_SCHED_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] tmo_cnt;
  logic                    err_r;
  logic                    in_wait;

  assign in_wait = (state == S_BUSY) || (state == S_WAIT);
  assign tmo_hit = in_wait && (&tmo_cnt);
  assign err     = err_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      if (in_wait) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_hit) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (|req)     state_next = S_LOAD;
      S_LOAD:  if (last_beat) state_next = S_START;
      S_START: if (h_ready)  state_next = S_BUSY;
      S_BUSY: begin
        if (tmo_hit)       state_next = S_DONE;
        else if (!h_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tmo_hit || h_ready) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered handler-side outputs keep h_we and h_start a cycle apart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt     <= 2'b00;
      count   <= '0;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_data  <= 8'h00;
      h_start <= 1'b0;
    end else begin
      h_we    <= beat;
      h_start <= (state == S_START) && h_ready;
      if (state == S_IDLE && (|req)) begin
        gnt   <= arb_grant;
        count <= '0;
      end
      if (beat) begin
        h_addr <= count;
        h_data <= byte_in;
        if (!last_beat) begin
          count <= count + 1'b1;
        end
      end
      if (state == S_DONE) begin
        gnt <= 2'b00;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_job_scheduler.md
UART_JOB_SCHEDULER -- requirements
Module: uart_job_scheduler

Interface
REQ-001 Parameter RAM_SIZE, default 28, number of bytes per job loaded into the uart_handler RAM.
REQ-002 Parameter ADDR_BITS, default 5, width of the uart_handler RAM address.
REQ-003 Port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 Port req  input  2  per-requester job request, level.
REQ-006 Port gnt  output  2  one-hot grant; at most one bit set.
REQ-007 Port in_valid  input  2  per-requester byte valid.
REQ-008 Port in_data0 / in_data1  input  8 each  requester byte data.
REQ-009 Port in_ready  output  2  per-requester byte accept.
REQ-010 Port done  output  2  one-cycle job-complete pulse per requester.
REQ-011 Port h_addr  output  ADDR_BITS  RAM address to uart_handler.
REQ-012 Port h_we  output  1  RAM write enable to uart_handler.
REQ-013 Port h_data  output  8  RAM write data to uart_handler.
REQ-014 Port h_start  output  1  transmit start pulse to uart_handler.
REQ-015 Port h_ready  input  1  uart_handler idle, level (high = idle).
REQ-016 Port err  output  1  sticky timeout flag, cleared only by reset.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, START, BUSY, WAIT, DONE.
REQ-018 IDLE: if any req bit is set, SHALL grant by round-robin (the requester not granted last wins a tie; a lone requester wins regardless) and enter LOAD next cycle with count = 0.
REQ-019 LOAD: in_ready[g] = 1 only for the granted g; each accepted beat SHALL register h_we = 1, h_addr = count, h_data = in_data_g on the next cycle (latency 1), then count + 1.
REQ-020 LOAD SHALL exit to START after exactly RAM_SIZE beats; count never exceeds RAM_SIZE-1 and does not wrap.
REQ-021 Deassertion of req[g] during LOAD SHALL be ignored; the load completes.
REQ-022 START: when h_ready = 1, h_start SHALL pulse for exactly one cycle, then enter BUSY; while h_ready = 0, hold in START.
REQ-023 BUSY: wait for h_ready = 0 (handler acknowledged), then enter WAIT.
REQ-024 WAIT: on h_ready = 1, enter DONE.
REQ-025 DONE: done[g] SHALL pulse one cycle, gnt clears, the round-robin pointer updates to g, and the FSM returns to IDLE.
REQ-026 gnt SHALL stay stable from grant through DONE; a new req arriving mid-job SHALL wait.
REQ-027 h_we, h_start and done SHALL never be asserted in the same cycle.

Reset
REQ-028 Reset assertion SHALL asynchronously force state IDLE, count 0, pointer favouring req[0], and gnt, in_ready, done, h_we, h_start, h_addr, h_data and err all to 0.
REQ-029 Reset mid-job SHALL abandon the job without a done pulse; after release, arbitration restarts in IDLE.

Configuration
REQ-030 Macro UART_SCHED_TIMEOUT_EN defined: a 24-bit counter SHALL run in BUSY/WAIT; at 2^24-1 cycles it SHALL set err, pulse done[g] and return to IDLE.
REQ-031 Macro UART_SCHED_TIMEOUT_EN absent: there SHALL be no counter, err SHALL be tied to 0, and BUSY/WAIT SHALL wait indefinitely.

Structure
REQ-032 Package uart_sched_pkg SHALL hold the state enum, NUM_REQ = 2, the default RAM_SIZE/ADDR_BITS and the timeout width.
REQ-033 Sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant with a pointer-update input.

Verification
REQ-034 Only req = 01; stream bytes 0x00..0x1B -> 28 writes at addr 0..27 with matching data, one h_start, done = 01 after h_ready falls and then rises.
REQ-035 req = 11 from reset -> requester 0 served first, requester 1 next, then requester 0 again if still requesting.
REQ-036 in_valid toggled every other cycle -> still exactly 28 writes and no gaps in the address sequence.
REQ-037 h_ready held at 0 on entry to START for 10 cycles -> h_start is issued only on the first cycle with h_ready = 1.
REQ-038 Reset asserted at beat 12 -> all outputs are 0 immediately, no done pulse, and the next job starts at addr 0.
REQ-039 Macro defined and h_ready stuck low after start -> err = 1 and done pulses after 2^24-1 cycles.
